// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu : memory stage sitting directly after execute.
//   - Registers execute-stage writeback results for non-memory ops (1 cycle).
//   - Runs data-memory loads/stores (oh 11..18) over a req/ack bus.
//   - Stalls the pipeline through hold2ctrl while an access is outstanding.
//   - Aborts an access with a bus_err pulse after TIMEOUT cycles without ack.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid, oh, mem_addr,     execute-stage op, address, store data,
//   store_data, rd_addr_in,     destination register and ALU result
//   rd_data_in, rd_wen_in
//   rd_addr, rd_data,           registered writeback towards the register file
//   rd_wen2reg
//   hold2ctrl                   stall request to ctrl
//   misalign_err, bus_err       single-cycle error pulses
//   dmem_req/we/be/addr/wdata   data-memory request (held until ack)
//   dmem_ack, dmem_rdata        data-memory response
// -----------------------------------------------------------------------------
module mem_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [6:0]  oh,
    input  logic [31:0] mem_addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_addr_in,
    input  logic [31:0] rd_data_in,
    input  logic        rd_wen_in,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_wen2reg,
    output logic        hold2ctrl,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [6:0] OP_LB  = 7'd11;
    localparam logic [6:0] OP_LH  = 7'd12;
    localparam logic [6:0] OP_LW  = 7'd13;
    localparam logic [6:0] OP_LBU = 7'd14;
    localparam logic [6:0] OP_LHU = 7'd15;
    localparam logic [6:0] OP_SB  = 7'd16;
    localparam logic [6:0] OP_SH  = 7'd17;
    localparam logic [6:0] OP_SW  = 7'd18;

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    state_t        state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          req_q,     req_d;
    logic          we_q,      we_d;
    logic [3:0]    be_q,      be_d;
    logic [31:0]   addr_q,    addr_d;
    logic [31:0]   wdata_q,   wdata_d;
    logic [6:0]    op_q,      op_d;
    logic [1:0]    off_q,     off_d;
    logic [4:0]    lrd_q,     lrd_d;
    logic [4:0]    rd_addr_q, rd_addr_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          rd_wen_q,  rd_wen_d;
    logic          mis_q,     mis_d;
    logic          berr_q,    berr_d;

    // Decode of the incoming op
    logic        is_load, is_store, is_mem;
    logic        sz_byte, sz_half, sz_word;
    logic        aligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    always_comb begin
        is_load   = (oh >= OP_LB) && (oh <= OP_LHU);
        is_store  = (oh >= OP_SB) && (oh <= OP_SW);
        is_mem    = is_load || is_store;
        sz_byte   = (oh == OP_LB) || (oh == OP_LBU) || (oh == OP_SB);
        sz_half   = (oh == OP_LH) || (oh == OP_LHU) || (oh == OP_SH);
        sz_word   = (oh == OP_LW) || (oh == OP_SW);
        aligned   = sz_byte
                 || (sz_half && !mem_addr[0])
                 || (sz_word && (mem_addr[1:0] == 2'b00));
        be_new    = 4'b1111;
        wdata_new = '0;
        case (oh)
            OP_SB: begin
                be_new    = 4'b0001 << mem_addr[1:0];
                wdata_new = {4{store_data[7:0]}};
            end
            OP_SH: begin
                be_new    = mem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{store_data[15:0]}};
            end
            OP_SW: begin
                be_new    = 4'b1111;
                wdata_new = store_data;
            end
            default: ;
        endcase
    end

    // Load data alignment and extension; the latched byte offset shifts the
    // addressed lane down to bit 0 (half accesses are already 2-aligned).
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic        op_is_load;

    always_comb begin
        shifted    = dmem_rdata >> {off_q, 3'b000};
        op_is_load = (op_q >= OP_LB) && (op_q <= OP_LHU);
        case (op_q)
            OP_LB:   load_val = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_val = {24'd0, shifted[7:0]};
            OP_LH:   load_val = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_val = {16'd0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // Next-state / output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        op_d      = op_q;
        off_d     = off_q;
        lrd_d     = lrd_q;
        rd_addr_d = '0;
        rd_data_d = '0;
        rd_wen_d  = 1'b0;
        mis_d     = 1'b0;
        berr_d    = 1'b0;
        hold2ctrl = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        rd_addr_d = rd_addr_in;
                        rd_data_d = rd_data_in;
                        rd_wen_d  = rd_wen_in && (rd_addr_in != 5'd0);
                    end else if (!aligned) begin
                        mis_d = 1'b1;
                    end else begin
                        hold2ctrl = 1'b1;
                        state_d   = S_REQ;
                        cnt_d     = '0;
                        req_d     = 1'b1;
                        we_d      = is_store;
                        be_d      = be_new;
                        addr_d    = {mem_addr[31:2], 2'b00};
                        wdata_d   = wdata_new;
                        op_d      = oh;
                        off_d     = mem_addr[1:0];
                        lrd_d     = rd_addr_in;
                    end
                end
            end

            S_REQ: begin
                hold2ctrl = !dmem_ack;
                // Ack is tested first so that it wins over a same-cycle timeout.
                if (dmem_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = '0;
                    addr_d  = '0;
                    wdata_d = '0;
                    if (dmem_ack) begin
                        if (op_is_load) begin
                            rd_addr_d = lrd_q;
                            rd_data_d = load_val;
                            rd_wen_d  = (lrd_q != 5'd0);
                        end
                    end else begin
                        berr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            op_q      <= '0;
            off_q     <= '0;
            lrd_q     <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            rd_wen_q  <= 1'b0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            op_q      <= op_d;
            off_q     <= off_d;
            lrd_q     <= lrd_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            rd_wen_q  <= rd_wen_d;
            mis_q     <= mis_d;
            berr_q    <= berr_d;
        end
    end

    assign rd_addr      = rd_addr_q;
    assign rd_data      = rd_data_q;
    assign rd_wen2reg   = rd_wen_q;
    assign misalign_err = mis_q;
    assign bus_err      = berr_q;
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_be      = be_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_lsu : directed + randomized bench for mem_lsu (TIMEOUT = 4).
// Expected values come from a transaction-level model of the access rules.
// -----------------------------------------------------------------------------
module tb_mem_lsu;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [6:0]  oh;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic [4:0]  rd_addr_in;
    logic [31:0] rd_data_in;
    logic        rd_wen_in;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_wen2reg;
    logic        hold2ctrl;
    logic        misalign_err;
    logic        bus_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int npass = 0;
    int nchk  = 0;

    mem_lsu #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .oh           (oh),
        .mem_addr     (mem_addr),
        .store_data   (store_data),
        .rd_addr_in   (rd_addr_in),
        .rd_data_in   (rd_data_in),
        .rd_wen_in    (rd_wen_in),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_wen2reg   (rd_wen2reg),
        .hold2ctrl    (hold2ctrl),
        .misalign_err (misalign_err),
        .bus_err      (bus_err),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_be      (dmem_be),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int unsigned sz(input int unsigned op);
        if (op == 11 || op == 14 || op == 16) return 1;
        if (op == 12 || op == 15 || op == 17) return 2;
        return 4;
    endfunction

    function automatic bit is_ld(input int unsigned op);
        return (op >= 11) && (op <= 15);
    endfunction

    function automatic logic [31:0] exp_be(input int unsigned op, input logic [31:0] a);
        if (is_ld(op)) return 32'hF;
        return ((32'd1 << sz(op)) - 32'd1) << (a % 4);
    endfunction

    function automatic logic [31:0] exp_wdata(input int unsigned op, input logic [31:0] d);
        if (is_ld(op)) return 32'd0;
        if (sz(op) == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz(op) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input int unsigned op, input logic [31:0] a,
                                             input logic [31:0] w);
        int unsigned s   = sz(op);
        logic [31:0] m   = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
        logic [31:0] v   = (w >> (8 * (a % 4))) & m;
        bit          sgn = (op == 11) || (op == 12);
        if (sgn && v[8*s-1]) v = v | ~m;
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Non-memory op: registered after one edge.
    task automatic do_alu(input logic [4:0] rd, input logic [31:0] d, input logic wen);
        int unsigned v = $urandom_range(0, 116);
        in_valid   = 1'b1;
        oh         = 7'((v < 11) ? v : v + 8);
        mem_addr   = $urandom;
        store_data = $urandom;
        rd_addr_in = rd;
        rd_data_in = d;
        rd_wen_in  = wen;
        #1 chk("alu_hold", hold2ctrl, 0);
        @(posedge clk); #1;
        chk("alu_rd_addr", rd_addr, rd);
        chk("alu_rd_data", rd_data, d);
        chk("alu_wen", rd_wen2reg, (wen && rd != 0));
    endtask

    task automatic do_bubble();
        in_valid   = 1'b0;
        oh         = 7'd13;
        rd_addr_in = 5'd7;
        rd_data_in = $urandom;
        rd_wen_in  = 1'b1;
        @(posedge clk); #1;
        chk("bub_wen", rd_wen2reg, 0);
        chk("bub_rd_data", rd_data, 0);
        chk("bub_rd_addr", rd_addr, 0);
    endtask

    // Memory op; ackd = REQ cycles without ack before the ack cycle, -1 = never.
    task automatic do_mem(input int unsigned op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] rd, input int ackd, input logic [31:0] rdat);
        bit al    = (a % sz(op)) == 0;
        bit timed = !(ackd >= 0 && ackd < TO);
        bit ackn;
        in_valid   = 1'b1;
        oh         = 7'(op);
        mem_addr   = a;
        store_data = sd;
        rd_addr_in = rd;
        rd_data_in = $urandom;
        rd_wen_in  = 1'b1;
        dmem_ack   = 1'b0;
        #1 chk("issue_hold", hold2ctrl, al);
        @(posedge clk); #1;
        if (!al) begin
            in_valid = 1'b0;
            #1;
            chk("mis_pulse", misalign_err, 1);
            chk("mis_req", dmem_req, 0);
            chk("mis_wen", rd_wen2reg, 0);
            chk("mis_hold", hold2ctrl, 0);
            @(posedge clk); #1;
            chk("mis_pulse_end", misalign_err, 0);
            chk("mis_req2", dmem_req, 0);
            return;
        end
        chk("issue_wen", rd_wen2reg, 0);
        for (int k = 0; k < TO; k++) begin
            ackn       = (k == ackd);
            dmem_ack   = ackn;
            dmem_rdata = ackn ? rdat : $urandom;
            #1;
            chk("req", dmem_req, 1);
            chk("we", dmem_we, !is_ld(op));
            chk("be", dmem_be, exp_be(op, a));
            chk("addr", dmem_addr, a & 32'hFFFF_FFFC);
            chk("wdata", dmem_wdata, exp_wdata(op, sd));
            chk("req_hold", hold2ctrl, !ackn);
            @(posedge clk); #1;
            if (ackn) break;
        end
        dmem_ack = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("done_req", dmem_req, 0);
        chk("done_hold", hold2ctrl, 0);
        chk("bus_err", bus_err, timed);
        if (!timed && is_ld(op)) begin
            chk("ld_data", rd_data, exp_load(op, a, rdat));
            chk("ld_rd", rd_addr, rd);
            chk("ld_wen", rd_wen2reg, rd != 0);
        end else begin
            chk("nowb_wen", rd_wen2reg, 0);
        end
        @(posedge clk); #1;
        chk("bus_err_end", bus_err, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        oh         = '0;
        mem_addr   = '0;
        store_data = '0;
        rd_addr_in = '0;
        rd_data_in = '0;
        rd_wen_in  = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_wen", rd_wen2reg, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_hold", hold2ctrl, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_berr", bus_err, 0);
        chk("rst_mis", misalign_err, 0);
        rst_n = 1'b1;

        // directed
        do_alu(5'd5, 32'h0000_1234, 1'b1);
        do_alu(5'd0, 32'h0000_1234, 1'b1);
        do_alu(5'd9, 32'hDEAD_BEEF, 1'b0);
        do_bubble();
        do_mem(11, 32'h0000_0103, 32'h0, 5'd3, 3, 32'h80FF_FF00);
        do_mem(17, 32'h0000_0202, 32'hABCD_1234, 5'd4, 1, 32'h0);
        do_mem(13, 32'h0000_0101, 32'h0, 5'd6, 0, 32'h0);
        do_mem(18, 32'h0000_0300, 32'h1122_3344, 5'd0, -1, 32'h0);
        do_mem(18, 32'h0000_0304, 32'h5566_7788, 5'd0, 3, 32'h0);
        do_mem(13, 32'h0000_0400, 32'h0, 5'd0, 0, 32'h1234_5678);
        do_mem(12, 32'h0000_0502, 32'h0, 5'd8, 2, 32'h8001_7FFF);
        do_mem(15, 32'h0000_0502, 32'h0, 5'd8, 0, 32'h8001_7FFF);
        do_mem(14, 32'h0000_0601, 32'h0, 5'd1, -1, 32'h0);

        // reset in the middle of an outstanding request
        in_valid   = 1'b1;
        oh         = 7'd18;
        mem_addr   = 32'h0000_0700;
        store_data = 32'hCAFE_F00D;
        rd_addr_in = 5'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_req", dmem_req, 1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_req", dmem_req, 0);
        chk("mid_rst_we", dmem_we, 0);
        chk("mid_rst_be", dmem_be, 0);
        chk("mid_rst_addr", dmem_addr, 0);
        chk("mid_rst_wdata", dmem_wdata, 0);
        chk("mid_rst_hold", hold2ctrl, 0);
        chk("mid_rst_wen", rd_wen2reg, 0);
        chk("mid_rst_berr", bus_err, 0);
        rst_n = 1'b1;
        do_mem(16, 32'h0000_0803, 32'h0000_00A5, 5'd0, 0, 32'h0);
        do_alu(5'd31, 32'h0BAD_F00D, 1'b1);

        // randomized
        for (int i = 0; i < 150; i++) begin
            int unsigned r = $urandom_range(0, 9);
            if (r <= 2) begin
                do_alu(5'($urandom), $urandom, 1'($urandom));
            end else if (r == 3) begin
                do_bubble();
            end else begin
                int a = $urandom_range(0, 4);
                do_mem($urandom_range(11, 18), $urandom, $urandom, 5'($urandom),
                       (a == 4) ? -1 : a, $urandom);
            end
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
